// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0]  NINE  = 4'd9;

  // Double-dabble correction: a digit of 5..9 would exceed 9 after doubling.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit conditional +3 corrector; no carry out of the digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  assign d_o = add3(d_i);

endmodule

// File: rtl/bcd_ndigit.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake.
// Define BCD_SAT_EN to clamp overflowed results to all nines.
module bcd_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = BCD_W * (DIGITS + 1);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    sr_q, sr_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic [4*DIGITS-1:0] result;
  logic                guard_nz;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (acc_q[g*BCD_W +: BCD_W]),
      .d_o (acc_adj[g*BCD_W +: BCD_W])
    );
  end

  // The guard digit catches any value too large for the visible digits.
  assign guard_nz = (acc_q[ACC_W-1 -: BCD_W] != '0);

  always_comb begin
    result = acc_q[4*DIGITS-1:0];
`ifdef BCD_SAT_EN
    if (guard_nz) result = {DIGITS{NINE}};
`endif
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      SHIFT: begin
        {acc_d, sr_d} = {acc_adj[ACC_W-2:0], sr_q, 1'b0};
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        dig_d   = result;
        ovf_d   = guard_nz;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new request is taken in IDLE and also in the DONE cycle.
    if (start && (state_q != SHIFT)) begin
      sr_d    = value;
      acc_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
      state_d = SHIFT;
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = dig_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_ndigit.sv
// Randomised self-checking bench for bcd_ndigit (4x14 and 6x20 instances).
module tb_bcd_ndigit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] value = '0;
  logic        busy, done, overflow;
  logic [15:0] digits;

  logic        start6 = 1'b0;
  logic [19:0] value6 = '0;
  logic        busy6, done6, overflow6;
  logic [23:0] digits6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_ndigit #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .digits(digits), .overflow(overflow)
  );

  bcd_ndigit #(.DIGITS(6), .BIN_W(20)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .value(value6),
    .busy(busy6), .done(done6), .digits(digits6), .overflow(overflow6)
  );

  // Decimal reference: digits are value mod 10^nd, overflow when value >= 10^nd.
  function automatic void ref_model(input longint v, input int nd,
                                    output logic [31:0] dig, output logic ovf);
    longint lim = 1;
    longint t = v;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (v >= lim);
    dig = '0;
    for (int i = 0; i < nd; i++) begin
      dig[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BCD_SAT_EN
    if (ovf) for (int i = 0; i < nd; i++) dig[4*i +: 4] = 4'd9;
`endif
  endfunction

  task automatic run_conv(input logic [13:0] v);
    logic [31:0] ed;
    logic        eo;
    logic [15:0] prev;
    int          lat;
    ref_model(longint'(v), 4, ed, eo);
    prev = digits;
    @(negedge clk); start = 1'b1; value = v;
    @(negedge clk); start = 1'b0; value = 14'($urandom);
    lat = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start v=%0d got %b want 1", v, busy); end
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin
        checks++;
        if (digits !== prev) begin errors++; $display("FAIL digits_hold v=%0d got %h want %h", v, digits, prev); end
      end
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != 15) begin errors++; $display("FAIL latency v=%0d got %0d want 15", v, lat); end
    checks++;
    if (digits !== ed[15:0] || overflow !== eo)
      begin errors++; $display("FAIL result v=%0d got %h/%b want %h/%b", v, digits, overflow, ed[15:0], eo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done v=%0d got %b want 0", v, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse v=%0d got %b want 0", v, done); end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #4;
    checks++;
    if ({busy, done, digits, overflow} !== '0 || {busy6, done6, digits6, overflow6} !== '0)
      begin errors++; $display("FAIL reset_state got %b%b%h%b want all zero", busy, done, digits, overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_conv(14'd0);
    run_conv(14'd9999);
    run_conv(14'd1234);
    run_conv(14'd12345);
    run_conv(14'd16383);
    run_conv(14'd10000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) run_conv(14'($urandom_range(0, 16383)));
  endtask

  task automatic test_ignore_start();
    logic [13:0] v1, v2;
    logic [31:0] ed;
    logic        eo;
    logic [15:0] cap;
    logic        capo;
    int          ndone, dlat;
    v1 = 14'($urandom_range(0, 9999));
    v2 = v1 ^ 14'h2A5A;
    ref_model(longint'(v1), 4, ed, eo);
    ndone = 0; dlat = -1; cap = '0; capo = 1'b0;
    @(negedge clk); start = 1'b1; value = v1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      start = (k == 3 || k == 8);
      if (start) value = v2;
      @(negedge clk);
      if (done === 1'b1) begin ndone++; dlat = k + 1; cap = digits; capo = overflow; end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ignore_start_count got %0d want 1", ndone); end
    checks++;
    if (dlat != 15) begin errors++; $display("FAIL ignore_start_latency got %0d want 15", dlat); end
    checks++;
    if (cap !== ed[15:0] || capo !== eo)
      begin errors++; $display("FAIL ignore_start_result got %h/%b want %h/%b", cap, capo, ed[15:0], eo); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk); start = 1'b1; value = 14'd8765;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, digits, overflow} !== '0)
      begin errors++; $display("FAIL reset_mid got %b%b%h%b want all zero", busy, done, digits, overflow); end
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) ndone++; end
    rst = 1'b1;
    repeat (12) begin @(negedge clk); if (done === 1'b1) ndone++; end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL reset_mid_done got %0d want 0", ndone); end
    run_conv(14'd42);
    checks++;
    if (digits !== 16'h0042) begin errors++; $display("FAIL after_reset_42 got %h want 0042", digits); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed1, ed2;
    logic        eo1, eo2;
    int          lat;
    ref_model(64'd999999, 6, ed1, eo1);
    ref_model(64'd1048575, 6, ed2, eo2);
    @(negedge clk); start6 = 1'b1; value6 = 20'd999999;
    @(negedge clk); start6 = 1'b0;
    lat = 0;
    while (lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (busy6 !== 1'b0 || done6 !== 1'b0)
      begin errors++; $display("FAIL b2b_done_cycle got busy=%b done=%b want 0/0", busy6, done6); end
    start6 = 1'b1; value6 = 20'd1048575;
    @(negedge clk); start6 = 1'b0; value6 = '0;
    checks++;
    if (done6 !== 1'b1 || digits6 !== ed1[23:0] || overflow6 !== eo1)
      begin errors++; $display("FAIL b2b_first got %b/%h/%b want 1/%h/%b", done6, digits6, overflow6, ed1[23:0], eo1); end
    checks++;
    if (busy6 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy6); end
    lat = 0;
    @(negedge clk); lat++;
    while (done6 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL b2b_latency got %0d want 21", lat); end
    checks++;
    if (digits6 !== ed2[23:0] || overflow6 !== eo2)
      begin errors++; $display("FAIL b2b_second got %h/%b want %h/%b", digits6, overflow6, ed2[23:0], eo2); end
  endtask

  task automatic test_random_wide();
    logic [19:0] v;
    logic [31:0] ed;
    logic        eo;
    int          lat;
    for (int n = 0; n < 6; n++) begin
      v = 20'($urandom);
      ref_model(longint'(v), 6, ed, eo);
      @(negedge clk); start6 = 1'b1; value6 = v;
      @(negedge clk); start6 = 1'b0;
      lat = 0;
      while (done6 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
      checks++;
      if (lat != 21 || digits6 !== ed[23:0] || overflow6 !== eo)
        begin errors++; $display("FAIL wide v=%0d got %0d/%h/%b want 21/%h/%b", v, lat, digits6, overflow6, ed[23:0], eo); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_ndigit.md
# bcd_ndigit

Parametrised sequential binary-to-BCD converter for the CoolRunner-II display path, successor to the fixed 4-digit converter. Iterative shift-add-3 (double-dabble) over BIN_W cycles, with a start/busy/done handshake, configurable digit count and overflow detection. Sits between the value source and the 7-segment digit multiplexer, which consumes the packed digit bus.

## Interface
- DIGITS, 4: number of output BCD digits.
- BIN_W, 14: binary input width. Legal only if 2^BIN_W - 1 < 10^(DIGITS+1).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of `value`; accepted only when `busy`=0.
- value  input  BIN_W  unsigned binary operand, sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; `digits`/`overflow` updated on the same edge.
- digits  output  4*DIGITS  packed BCD; digit 0 (least significant) in [3:0].
- overflow  output  1  result exceeds 10^DIGITS - 1.

## Operation
- One clock; reset is asynchronous and active-low.
- Reset: state IDLE; `busy`=0, `done`=0, `digits`=0, `overflow`=0, internal shift registers cleared.
- Internal BCD accumulator holds DIGITS+1 digits (guard digit); binary shift register BIN_W bits; iteration counter ceil(log2(BIN_W+1)) bits.
- States:
  - IDLE: `start`=1 -> load `value` into shift register, clear accumulator, counter=BIN_W, go SHIFT.
  - SHIFT: each cycle, every accumulator digit >= 5 gets +3, then {accumulator, shift register} shifts left by 1 (binary MSB enters accumulator bit 0); counter decrements. After the BIN_W-th shift, go DONE.
  - DONE: register result to `digits`, set `overflow` = (guard digit != 0), pulse `done`, go IDLE; if `start`=1 in this cycle, it is accepted and next state is SHIFT instead.
- `start` while `busy`=1: ignored, no queueing, `value` not sampled.
- `digits`/`overflow` hold their last result until the next DONE; they never show intermediate values.
- Reset asserted mid-conversion: immediate return to IDLE, all outputs to reset values, partial result discarded.
- All arithmetic unsigned; the +3 correction is per 4-bit digit and never carries between digits.

## Timing
- `start` accepted at edge 0 -> `busy` high from edge 0 through edge BIN_W; DONE occupies cycle BIN_W+1; `done` high for exactly one cycle, `digits` valid from that edge.
- Latency start-to-done: BIN_W+1 cycles (15 for defaults).
- `busy`=0 during DONE, so back-to-back throughput is one result per BIN_W+1 cycles.
- `busy`, `done`, `digits`, `overflow` are all registered outputs.

## Configuration
- BCD_SAT_EN defined: on overflow, `digits` = all 9s (DIGITS nines); `overflow`=1.
- BCD_SAT_EN undefined: on overflow, `digits` = low DIGITS digits of the true result (value mod 10^DIGITS); `overflow`=1.
- No overflow: identical behaviour either way.

## Structure
- Package `bcd_pkg`: state enumeration (IDLE, SHIFT, DONE), BCD digit width constant (4), nine-digit constant 4'd9, add-3 correction function.
- One sub-module: `bcd_add3` (single-digit conditional +3 corrector, combinational), instantiated DIGITS+1 times via generate.
- Counter width and accumulator width derived from parameters inside the top module.

## Test plan
- Reset, then `value`=0, pulse `start` -> `done` at cycle 15, `digits`=16'h0000, `overflow`=0.
- `value`=9999 -> `digits`=16'h9999, `overflow`=0; `value`=1234 -> 16'h1234.
- `value`=12345 -> `overflow`=1; `digits`=16'h9999 with BCD_SAT_EN, 16'h2345 without.
- `start` pulsed at cycles 3 and 8 of a running conversion with different `value` -> ignored, single `done`, first value's result.
- Reset asserted at cycle 7 of a conversion -> all outputs 0 immediately, no `done`; next `start` with 42 -> 16'h0042.
- DIGITS=6, BIN_W=20: `value`=999999 -> 24'h999999, `overflow`=0; back-to-back `start` in DONE cycle with 1048575 -> second `done` 21 cycles later, `overflow`=1.
